// File: rtl/parity_frame_sched.sv
// parity_frame_sched
// Two requesters share one parity encoder. A round-robin arbiter accepts one
// nibble at a time. The nibble and its parity are latched, then sent on the
// serial line as a frame: start(0), data LSB-first, parity, stop(1).
// Every serial bit is held for BIT_CYCLES clocks.
// Optional build macro PARITY_FRAME_ODD_EN: when defined, the latched parity
// is inverted (odd parity). Arbitration, timing and framing stay the same.
module parity_frame_sched #(
    parameter int DATA_W     = 4,
    parameter int BIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              tx,
    output logic              busy,
    output logic              gnt_id,
    output logic              parity,
    output logic              frame_done
);

    localparam int          BIT_W       = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [7:0]  LP_LAST_CYC = 8'(BIT_CYCLES - 1);
    localparam logic [BIT_W-1:0] LP_LAST_BIT = BIT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t             r_state;
    state_t             w_nextState;
    logic [7:0]         r_cycleCnt;
    logic [BIT_W-1:0]   r_bitCnt;
    logic [DATA_W-1:0]  r_shift;
    logic               r_parity;
    logic               r_gntId;
    // r_rrPtr holds the requester granted last; it resets to 1 so req0 wins first
    logic               r_rrPtr;

    logic               w_pick0;
    logic               w_pick1;
    logic               w_accept;
    logic [DATA_W-1:0]  w_acceptData;
    logic               w_acceptParity;
    logic               w_bitEnd;
    logic               w_lastBit;

    assign w_bitEnd  = (r_cycleCnt == LP_LAST_CYC);
    assign w_lastBit = (r_bitCnt == LP_LAST_BIT);

    // Round-robin choice: a lone requester wins, a tie goes to the one not granted last
    always_comb begin
        w_pick0 = req0_valid && (!req1_valid || r_rrPtr);
        w_pick1 = req1_valid && (!req0_valid || !r_rrPtr);
        req0_ready = (r_state == S_IDLE) && w_pick0;
        req1_ready = (r_state == S_IDLE) && w_pick1;
        w_accept = req0_ready || req1_ready;
        w_acceptData = req1_ready ? req1_data : req0_data;
`ifdef PARITY_FRAME_ODD_EN
        w_acceptParity = ~(^w_acceptData);
`else
        w_acceptParity = ^w_acceptData;
`endif
    end

    // Frame sequencing: each state lasts one bit time, DATA lasts DATA_W bit times
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE:   if (w_accept)              w_nextState = S_START;
            S_START:  if (w_bitEnd)              w_nextState = S_DATA;
            S_DATA:   if (w_bitEnd && w_lastBit) w_nextState = S_PARITY;
            S_PARITY: if (w_bitEnd)              w_nextState = S_STOP;
            S_STOP:   if (w_bitEnd)              w_nextState = S_IDLE;
            default:                             w_nextState = S_IDLE;
        endcase
    end

    // Line driver and status; tx follows the state so reset forces it high at once
    always_comb begin
        tx         = 1'b1;
        busy       = (r_state != S_IDLE);
        frame_done = 1'b0;
        case (r_state)
            S_START:  tx = 1'b0;
            S_DATA:   tx = r_shift[0];
            S_PARITY: tx = r_parity;
            S_STOP: begin
                tx         = 1'b1;
                frame_done = w_bitEnd;
            end
            default:  tx = 1'b1;
        endcase
    end

    assign gnt_id = r_gntId;
    assign parity = r_parity;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Bit-time and bit-index counters; both rest at zero while idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cycleCnt <= 8'd0;
            r_bitCnt   <= '0;
        end else if (r_state == S_IDLE) begin
            r_cycleCnt <= 8'd0;
            r_bitCnt   <= '0;
        end else if (w_bitEnd) begin
            r_cycleCnt <= 8'd0;
            if (r_state == S_DATA) begin
                r_bitCnt <= w_lastBit ? '0 : r_bitCnt + BIT_W'(1);
            end
        end else begin
            r_cycleCnt <= r_cycleCnt + 8'd1;
        end
    end

    // Accept path latches nibble, parity and owner; DATA shifts out one bit per bit time
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift  <= '0;
            r_parity <= 1'b0;
            r_gntId  <= 1'b0;
            r_rrPtr  <= 1'b1;
        end else if (w_accept) begin
            r_shift  <= w_acceptData;
            r_parity <= w_acceptParity;
            r_gntId  <= req1_ready;
            r_rrPtr  <= req1_ready;
        end else if (r_state == S_DATA && w_bitEnd) begin
            r_shift  <= r_shift >> 1;
        end
    end

endmodule
